ps2_keycode_rx: RTL and testbench

//   PS/2 keyboard receiver upstream of the mode controller. Deserialises device->host frames,

---
 rtl/ps2_keycode_rx.sv | 174 +++++++++++++++++
 tb/tb_ps2_keycode_rx.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_keycode_rx.sv
// ---------------------------------------------------------------------------
// ps2_keycode_rx
//   PS/2 keyboard receiver. Conditions the asynchronous PS/2 lines, frames
//   device->host bytes (start, 8 data LSB first, odd parity, stop), decodes
//   the E0 (extended) and F0 (break) prefixes, and presents the make code of
//   the currently held key.
//
// Ports
//   clk           system clock, all registers on its rising edge
//   rst_n         asynchronous active-low reset
//   ps2_clk       PS/2 clock line (asynchronous)
//   ps2_data      PS/2 data line (asynchronous)
//   key_code      make code of the held key, 0x00 when none is held
//   key_extended  held key was E0-prefixed
//   key_valid     one-cycle pulse per accepted make code (repeats included)
//   frame_err     one-cycle pulse on parity, stop-bit or timeout failure
// ---------------------------------------------------------------------------
module ps2_keycode_rx #(
   parameter int FILTER_LEN     = 4,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] key_code,
   output logic       key_extended,
   output logic       key_valid,
   output logic       frame_err
);

   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   logic          ps2_clk_p0, ps2_clk_p1;
   logic          ps2_data_p0, ps2_data_p1;
   logic          clk_filt, clk_filt_d;
   logic [FW-1:0] filt_cnt;
   logic          fall;

   state_t        state;
   logic [2:0]    bit_cnt;
   logic [TW-1:0] to_cnt;
   logic          brk_pending, ext_pending;
   logic [7:0]    shreg;
   logic          par_bit;
   logic          byte_ok;

   // --- stage p0/p1: two-flop synchronisers; idle PS/2 lines are high
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ps2_clk_p0  <= 1'b1;
         ps2_clk_p1  <= 1'b1;
         ps2_data_p0 <= 1'b1;
         ps2_data_p1 <= 1'b1;
      end else begin
         ps2_clk_p0  <= ps2_clk;
         ps2_clk_p1  <= ps2_clk_p0;
         ps2_data_p0 <= ps2_data;
         ps2_data_p1 <= ps2_data_p0;
      end
   end

   // --- clock filter: the filtered clock follows the synced clock only
   //     after FILTER_LEN consecutive samples that disagree with it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_filt   <= 1'b1;
         clk_filt_d <= 1'b1;
         filt_cnt   <= '0;
      end else begin
         clk_filt_d <= clk_filt;
         if (ps2_clk_p1 != clk_filt) begin
            if (filt_cnt == FW'(FILTER_LEN - 1)) begin
               clk_filt <= ps2_clk_p1;
               filt_cnt <= '0;
            end else begin
               filt_cnt <= filt_cnt + FW'(1);
            end
         end else begin
            filt_cnt <= '0;
         end
      end
   end

   assign fall = clk_filt_d & ~clk_filt;

   // Shift register and parity bit are pure data; they need no reset because
   // the FSM never interprets them before a full frame has refilled them.
   always_ff @(posedge clk) begin
      if (fall) begin
         if (state == DATA)   shreg   <= {ps2_data_p1, shreg[7:1]};
         if (state == PARITY) par_bit <= ps2_data_p1;
      end
   end

   // Odd parity over data+parity and a high stop bit.
   assign byte_ok = ps2_data_p1 & (^{shreg, par_bit});

   // --- frame FSM, timeout and prefix decode; outputs registered here
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         bit_cnt      <= '0;
         to_cnt       <= '0;
         brk_pending  <= 1'b0;
         ext_pending  <= 1'b0;
         key_code     <= 8'h00;
         key_extended <= 1'b0;
         key_valid    <= 1'b0;
         frame_err    <= 1'b0;
      end else begin
         key_valid <= 1'b0;
         frame_err <= 1'b0;
         if (fall) begin
            to_cnt <= '0;
            case (state)
               IDLE: begin
                  // A high bit here is a stray clock edge, not a start bit.
                  if (!ps2_data_p1) begin
                     state   <= DATA;
                     bit_cnt <= '0;
                  end
               end
               DATA: begin
                  if (bit_cnt == 3'd7) state <= PARITY;
                  else                 bit_cnt <= bit_cnt + 3'd1;
               end
               PARITY: state <= STOP;
               STOP: begin
                  state <= IDLE;
                  if (!byte_ok) begin
                     frame_err   <= 1'b1;
                     brk_pending <= 1'b0;
                     ext_pending <= 1'b0;
                  end else if (shreg == 8'hF0) begin
                     brk_pending <= 1'b1;
                  end else if (shreg == 8'hE0) begin
                     ext_pending <= 1'b1;
                  end else begin
                     if (brk_pending) begin
                        // Only the release of the key actually held clears it.
                        if (shreg == key_code && ext_pending == key_extended) begin
                           key_code     <= 8'h00;
                           key_extended <= 1'b0;
                        end
                     end else begin
                        key_code     <= shreg;
                        key_extended <= ext_pending;
                        key_valid    <= 1'b1;
                     end
                     brk_pending <= 1'b0;
                     ext_pending <= 1'b0;
                  end
               end
               default: state <= IDLE;
            endcase
         end else if (state != IDLE) begin
            if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
               state       <= IDLE;
               to_cnt      <= '0;
               frame_err   <= 1'b1;
               brk_pending <= 1'b0;
               ext_pending <= 1'b0;
            end else begin
               to_cnt <= to_cnt + TW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_ps2_keycode_rx.sv
// ---------------------------------------------------------------------------
// tb_ps2_keycode_rx
//   Drives PS/2 frames into ps2_keycode_rx from a vector table plus a few
//   hand-written sequences (timeout, clock glitch, mid-frame reset). Expected
//   key_valid / frame_err events are queued when a frame is sent and popped by
//   a monitor whenever the DUT pulses either output.
// ---------------------------------------------------------------------------
module tb_ps2_keycode_rx;

   localparam int FL = 4;
   localparam int TO = 1000;
   localparam int H  = 20;   // half PS/2 clock period in clk cycles

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic [7:0] key_code;
   logic       key_extended, key_valid, frame_err;

   int tests = 0;
   int fails = 0;

   typedef struct {
      bit         is_err;
      logic [7:0] code;
      bit         ext;
   } ev_t;

   typedef struct {
      logic [7:0] data;
      bit         bad_par;
      bit         stop_v;
      logic [7:0] exp_code;
      bit         exp_ext;
      int         ev;        // 0 none, 1 key_valid, 2 frame_err
   } vec_t;

   ev_t  exp_q[$];
   vec_t vt[23];

   ps2_keycode_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .key_code(key_code), .key_extended(key_extended),
      .key_valid(key_valid), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   initial begin
      #(600000 * 10);
      $display("FAIL watchdog: run did not finish, tests=%0d", tests);
      $fatal(1, "watchdog");
   end

   // Scoreboard monitor: every output pulse must match the queue head.
   always @(negedge clk) begin
      if (rst_n && (key_valid || frame_err)) begin
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_pulse: key_valid=%0b frame_err=%0b code=%02h, none expected",
                     key_valid, frame_err, key_code);
         end else begin
            ev_t e;
            e = exp_q.pop_front();
            if (e.is_err) begin
               if (!(frame_err && !key_valid)) begin
                  fails++;
                  $display("FAIL err_pulse: key_valid=%0b frame_err=%0b, required frame_err only",
                           key_valid, frame_err);
               end
            end else if (!(key_valid && !frame_err && key_code == e.code && key_extended == e.ext)) begin
               fails++;
               $display("FAIL make_pulse: valid=%0b err=%0b code=%02h ext=%0b, required valid code=%02h ext=%0b",
                        key_valid, frame_err, key_code, key_extended, e.code, e.ext);
            end
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic push_ev(input int ev, input logic [7:0] code, input bit ext);
      ev_t e;
      e.is_err = (ev == 2);
      e.code   = code;
      e.ext    = ext;
      if (ev != 0) exp_q.push_back(e);
   endtask

   // Sends the first nbits of a frame; glitch_bit >= 0 inserts a short low
   // pulse on ps2_clk while that bit is being presented.
   task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit stop_v,
                             input int nbits, input int glitch_bit);
      logic [10:0] fr;
      fr = {stop_v, (~^b) ^ bad_par, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         ps2_data = fr[i];
         cyc(H / 2);
         if (i == glitch_bit) begin
            ps2_clk = 1'b0;
            cyc(FL - 1);
            ps2_clk = 1'b1;
         end
         cyc(H);
         ps2_clk = 1'b0;
         cyc(H);
         ps2_clk = 1'b1;
      end
      if (nbits == 11) begin
         ps2_data = 1'b1;
         cyc(2 * H);
      end
   endtask

   task automatic drained(input string name);
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL %s: %0d expected pulses missing, required 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   initial begin
      vt[0]  = '{8'h16, 1'b0, 1'b1, 8'h16, 1'b0, 1};
      vt[1]  = '{8'hF0, 1'b0, 1'b1, 8'h16, 1'b0, 0};
      vt[2]  = '{8'h16, 1'b0, 1'b1, 8'h00, 1'b0, 0};
      vt[3]  = '{8'hE0, 1'b0, 1'b1, 8'h00, 1'b0, 0};
      vt[4]  = '{8'h75, 1'b0, 1'b1, 8'h75, 1'b1, 1};
      vt[5]  = '{8'hE0, 1'b0, 1'b1, 8'h75, 1'b1, 0};
      vt[6]  = '{8'hF0, 1'b0, 1'b1, 8'h75, 1'b1, 0};
      vt[7]  = '{8'h75, 1'b0, 1'b1, 8'h00, 1'b0, 0};
      vt[8]  = '{8'h76, 1'b1, 1'b1, 8'h00, 1'b0, 2};
      vt[9]  = '{8'h1E, 1'b0, 1'b1, 8'h1E, 1'b0, 1};
      vt[10] = '{8'hF0, 1'b0, 1'b1, 8'h1E, 1'b0, 0};
      vt[11] = '{8'h16, 1'b0, 1'b1, 8'h1E, 1'b0, 0};
      vt[12] = '{8'h1E, 1'b0, 1'b1, 8'h1E, 1'b0, 1};
      vt[13] = '{8'h16, 1'b0, 1'b1, 8'h16, 1'b0, 1};
      vt[14] = '{8'hF0, 1'b0, 1'b1, 8'h16, 1'b0, 0};
      vt[15] = '{8'h1E, 1'b1, 1'b1, 8'h16, 1'b0, 2};
      vt[16] = '{8'h16, 1'b0, 1'b1, 8'h16, 1'b0, 1};
      vt[17] = '{8'h5A, 1'b0, 1'b0, 8'h16, 1'b0, 2};
      vt[18] = '{8'hE0, 1'b0, 1'b1, 8'h16, 1'b0, 0};
      vt[19] = '{8'hF0, 1'b0, 1'b1, 8'h16, 1'b0, 0};
      vt[20] = '{8'h16, 1'b0, 1'b1, 8'h16, 1'b0, 0};
      vt[21] = '{8'hF0, 1'b0, 1'b1, 8'h16, 1'b0, 0};
      vt[22] = '{8'h16, 1'b0, 1'b1, 8'h00, 1'b0, 0};

      // Reset state
      cyc(5);
      chk("rst_key_code", 32'(key_code), 32'h00);
      chk("rst_key_ext", 32'(key_extended), 32'h0);
      chk("rst_key_valid", 32'(key_valid), 32'h0);
      chk("rst_frame_err", 32'(frame_err), 32'h0);
      rst_n = 1'b1;
      cyc(10);

      // Table-driven frames
      for (int i = 0; i < 23; i++) begin
         push_ev(vt[i].ev, vt[i].exp_code, vt[i].exp_ext);
         send_frame(vt[i].data, vt[i].bad_par, vt[i].stop_v, 11, -1);
         @(negedge clk);
         chk($sformatf("vec%0d_code", i), 32'(key_code), 32'(vt[i].exp_code));
         chk($sformatf("vec%0d_ext", i), 32'(key_extended), 32'(vt[i].exp_ext));
         drained($sformatf("vec%0d_events", i));
         cyc(1);
      end

      // Timeout: start + 4 data bits, then silence
      push_ev(2, 8'h00, 1'b0);
      send_frame(8'h5A, 1'b0, 1'b1, 5, -1);
      ps2_data = 1'b1;
      cyc(TO + 10);
      drained("timeout_err");
      push_ev(1, 8'h5A, 1'b0);
      send_frame(8'h5A, 1'b0, 1'b1, 11, -1);
      @(negedge clk);
      chk("after_timeout_code", 32'(key_code), 32'h5A);
      drained("after_timeout_events");
      cyc(1);

      // Short ps2_clk glitch during data bit 3
      push_ev(1, 8'h1E, 1'b0);
      send_frame(8'h1E, 1'b0, 1'b1, 11, 4);
      @(negedge clk);
      chk("glitch_code", 32'(key_code), 32'h1E);
      drained("glitch_events");
      cyc(1);

      // Asynchronous reset mid-frame
      send_frame(8'h76, 1'b0, 1'b1, 4, -1);
      #3 rst_n = 1'b0;
      #1;
      chk("async_rst_code", 32'(key_code), 32'h00);
      chk("async_rst_ext", 32'(key_extended), 32'h0);
      chk("async_rst_valid", 32'(key_valid), 32'h0);
      chk("async_rst_err", 32'(frame_err), 32'h0);
      ps2_data = 1'b1;
      ps2_clk  = 1'b1;
      cyc(3);
      rst_n = 1'b1;
      cyc(5);
      push_ev(1, 8'h1E, 1'b0);
      send_frame(8'h1E, 1'b0, 1'b1, 11, -1);
      @(negedge clk);
      chk("post_rst_code", 32'(key_code), 32'h1E);
      chk("post_rst_ext", 32'(key_extended), 32'h0);
      drained("post_rst_events");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
